mem_loader: RTL and testbench

- Writer-side counterpart to the 1024x32 program ROM: streams bytes from a host link (UART or debug port), packs them into 32-bit words, and writes them sequentially into a 1024x32 program RAM.
- Lets firmware be loaded at run time instead of via $readmemh.
- Sits between the host byte-stream receiver and the RAM write port.
- Asserts done once the image is complete.

---
 rtl/mem_loader_pkg.sv | 29 ++
 rtl/mem_loader_word_packer.sv | 48 ++++
 rtl/mem_loader.sv | 115 +++++++++++
 tb/tb_mem_loader.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_loader_pkg
// Brief    : Shared state encoding, byte-lane constants and defaults for the
//            program-RAM loader.
// Revision : 1.0 - initial release
// ============================================================================
package mem_loader_pkg;

  localparam int c_DEF_ADDR_W = 10;
  localparam int c_DEF_DEPTH  = 1024;
  localparam int c_LANES      = 4;
  localparam int c_LANE_W     = 8;
  localparam int c_WORD_W     = c_LANES * c_LANE_W;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Maps the arrival index of a byte within a word onto its byte lane.
  function automatic logic [1:0] lane_sel(input logic [1:0] cnt, input logic big);
    return big ? (2'd3 - cnt) : cnt;
  endfunction

endpackage : mem_loader_pkg
`default_nettype wire

// File: rtl/mem_loader_word_packer.sv
`default_nettype none
// ============================================================================
// Module   : mem_loader_word_packer
// Brief    : 2-bit byte counter plus lane register assembling 32-bit words.
// Revision : 1.0 - initial release
// ============================================================================
module mem_loader_word_packer
  import mem_loader_pkg::*;
#(
  parameter int BIG_ENDIAN = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                byte_en,
  input  logic [c_LANE_W-1:0] byte_data,
  output logic [c_WORD_W-1:0] word,
  output logic                last_byte
);

  logic [1:0]          r_cnt;
  logic [c_WORD_W-1:0] r_word;
  logic [1:0]          w_lane;

  assign w_lane    = lane_sel(r_cnt, BIG_ENDIAN != 0);
  assign last_byte = (r_cnt == 2'd3);

  // word already contains the byte being accepted, so the parent can latch
  // the complete word on the same edge as the final handshake.
  generate
    for (genvar i = 0; i < c_LANES; i++) begin : g_lane
      assign word[i*c_LANE_W +: c_LANE_W] =
        (byte_en && (w_lane == 2'(i))) ? byte_data : r_word[i*c_LANE_W +: c_LANE_W];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_cnt  <= 2'd0;
      r_word <= '0;
    end else if (byte_en) begin
      r_cnt  <= r_cnt + 2'd1;
      r_word <= word;
    end
  end

endmodule : mem_loader_word_packer
`default_nettype wire

// File: rtl/mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : mem_loader
// Brief    : Packs a host byte stream into 32-bit words and writes them to
//            program RAM. Optional MEM_LOADER_CHECKSUM_EN adds a word checksum.
// Revision : 1.0 - initial release
// ============================================================================
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int ADDR_W     = c_DEF_ADDR_W,
  parameter int DEPTH      = c_DEF_DEPTH,
  parameter int BIG_ENDIAN = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [c_WORD_W-1:0] mem_din,
  output logic                busy,
  output logic                done
`ifdef MEM_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]         checksum
`endif
);

  localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic                w_byte_en;
  logic                w_start_ok;
  logic                w_last_byte;
  logic [c_WORD_W-1:0] w_word;

  // in_ready is only ever high in COLLECT, so it doubles as the state qualifier.
  assign w_byte_en  = in_valid && in_ready;
  assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  mem_loader_word_packer #(
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (w_start_ok),
    .byte_en   (w_byte_en),
    .byte_data (in_data),
    .word      (w_word),
    .last_byte (w_last_byte)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      in_ready    <= 1'b0;
      mem_we      <= 1'b0;
      mem_address <= '0;
      mem_din     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state  <= ST_COLLECT;
            r_addr   <= '0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
          end
        end
        ST_COLLECT: begin
          if (w_byte_en && w_last_byte) begin
            r_state     <= ST_WRITE;
            in_ready    <= 1'b0;
            mem_we      <= 1'b1;
            mem_address <= r_addr;
            mem_din     <= w_word;
          end
        end
        ST_WRITE: begin
          mem_we <= 1'b0;
          if (r_addr == c_LAST_ADDR) begin
            r_state <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            r_state  <= ST_COLLECT;
            r_addr   <= r_addr + ADDR_W'(1);
            in_ready <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef MEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset || w_start_ok) begin
      checksum <= '0;
    end else if (r_state == ST_WRITE) begin
      checksum <= checksum + mem_din;
    end
  end
`endif

endmodule : mem_loader
`default_nettype wire

// File: tb/tb_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_loader
// Brief    : Self-checking bench for mem_loader (little/big endian, DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_loader;

  localparam int c_DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset, start, in_valid;
  logic [7:0] in_data;

  logic        le_in_ready, le_we, le_busy, le_done;
  logic [9:0]  le_addr;
  logic [31:0] le_din;
  logic        be_in_ready, be_we, be_busy, be_done;
  logic [9:0]  be_addr;
  logic [31:0] be_din;
  logic        ck_in_ready, ck_we, ck_busy, ck_done;
  logic [9:0]  ck_addr;
  logic [31:0] ck_din;
`ifdef MEM_LOADER_CHECKSUM_EN
  logic [31:0] ck_sum;
`endif

  always #5 clk = ~clk;

  mem_loader #(.ADDR_W(10), .DEPTH(c_DEPTH), .BIG_ENDIAN(0)) u_le (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(le_in_ready), .mem_we(le_we), .mem_address(le_addr), .mem_din(le_din),
    .busy(le_busy), .done(le_done)
`ifdef MEM_LOADER_CHECKSUM_EN
    , .checksum()
`endif
  );

  mem_loader #(.ADDR_W(10), .DEPTH(c_DEPTH), .BIG_ENDIAN(1)) u_be (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(be_in_ready), .mem_we(be_we), .mem_address(be_addr), .mem_din(be_din),
    .busy(be_busy), .done(be_done)
`ifdef MEM_LOADER_CHECKSUM_EN
    , .checksum()
`endif
  );

  mem_loader #(.ADDR_W(10), .DEPTH(2), .BIG_ENDIAN(0)) u_ck (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ck_in_ready), .mem_we(ck_we), .mem_address(ck_addr), .mem_din(ck_din),
    .busy(ck_busy), .done(ck_done)
`ifdef MEM_LOADER_CHECKSUM_EN
    , .checksum(ck_sum)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Behavioural model: tracks the bytes of the current image and derives
  // every expected output from byte counts.
  bit          m_loading = 0, m_wr = 0, m_done = 0, m_we = 0;
  logic [9:0]  m_addr = '0;
  logic [31:0] m_din_le = '0, m_din_be = '0;
  logic [7:0]  m_bytes[$];

  always @(posedge clk) begin
    int n;
    if (reset) begin
      m_loading = 0; m_wr = 0; m_done = 0;
      m_addr = '0; m_din_le = '0; m_din_be = '0;
      m_bytes.delete();
    end else if (m_wr) begin
      m_wr = 0;
      if (m_bytes.size() / 4 == c_DEPTH) begin
        m_loading = 0;
        m_done    = 1;
      end
    end else if (m_loading) begin
      if (in_valid) begin
        m_bytes.push_back(in_data);
        n = m_bytes.size();
        if (n % 4 == 0) begin
          m_wr     = 1;
          m_addr   = 10'(n / 4 - 1);
          m_din_le = {m_bytes[n-1], m_bytes[n-2], m_bytes[n-3], m_bytes[n-4]};
          m_din_be = {m_bytes[n-4], m_bytes[n-3], m_bytes[n-2], m_bytes[n-1]};
        end
      end
    end else if (start) begin
      m_loading = 1;
      m_done    = 0;
      m_bytes.delete();
    end
    m_we = m_wr;
  end

  int         we_cnt = 0;
  logic [9:0] we_addrs[$];

  always @(negedge clk) begin
    chk("le_in_ready", 32'(le_in_ready), 32'(m_loading && !m_wr));
    chk("le_busy",     32'(le_busy),     32'(m_loading));
    chk("le_done",     32'(le_done),     32'(m_done));
    chk("le_we",       32'(le_we),       32'(m_we));
    chk("le_addr",     32'(le_addr),     32'(m_addr));
    chk("le_din",      le_din,           m_din_le);
    chk("be_in_ready", 32'(be_in_ready), 32'(m_loading && !m_wr));
    chk("be_we",       32'(be_we),       32'(m_we));
    chk("be_addr",     32'(be_addr),     32'(m_addr));
    chk("be_din",      be_din,           m_din_be);
    if (le_we === 1'b1) begin
      we_cnt++;
      we_addrs.push_back(le_addr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Presents one byte, holding it until the loader takes it (bounded wait).
  task automatic send(input logic [7:0] b, input int gap);
    bit acc = 0;
    bit rdy;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_data  = b;
    in_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      rdy = le_in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        acc = 1;
        break;
      end
    end
    in_valid = 1'b0;
    if (!acc) chk("send_timeout", 32'(acc), 32'd1);
  endtask

  task automatic wait_done();
    for (int k = 0; k < 30 && le_done !== 1'b1; k++) tick();
    chk("wait_done", 32'(le_done), 32'd1);
  endtask

  initial begin
    int c0;
    reset = 1'b1; start = 1'b0; in_valid = 1'b1; in_data = 8'h55;
    repeat (3) begin
      tick();
      chk("rst_in_ready", 32'(le_in_ready), 32'd0);
      chk("rst_busy",     32'(le_busy),     32'd0);
      chk("rst_we",       32'(le_we),       32'd0);
    end
    reset = 1'b0; in_valid = 1'b0;
    repeat (2) tick();

    // First word, back-to-back bytes
    pulse_start();
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
    chk("w0_we",       32'(le_we),       32'd1);
    chk("w0_addr",     32'(le_addr),     32'd0);
    chk("w0_din_le",   le_din,           32'h44332211);
    chk("w0_din_be",   be_din,           32'h11223344);
    chk("w0_in_ready", 32'(le_in_ready), 32'd0);

    // Remaining words with gaps; start mid-load must be ignored
    for (int w = 1; w < c_DEPTH; w++) begin
      for (int i = 0; i < 4; i++) begin
        send(8'((w << 4) | i), int'($urandom_range(0, 2)));
        if (w == 1 && i == 1) pulse_start();
      end
    end
    wait_done();
    chk("full_we_cnt", 32'(we_cnt), 32'd4);
    for (int i = 0; i < 4; i++) chk("full_addr_seq", 32'(we_addrs[i]), 32'(i));

    // A 17th byte is never taken
    in_data = 8'h99; in_valid = 1'b1;
    repeat (4) begin
      tick();
      chk("extra_in_ready", 32'(le_in_ready), 32'd0);
    end
    in_valid = 1'b0;
    chk("extra_we_cnt", 32'(we_cnt), 32'd4);

    // Restart from DONE
    pulse_start();
    chk("restart_done", 32'(le_done), 32'd0);
    chk("restart_busy", 32'(le_busy), 32'd1);
    send(8'h01, 0); send(8'h02, 1); send(8'h03, 0); send(8'h04, 0);
    chk("restart_addr", 32'(le_addr), 32'd0);
    chk("restart_din",  le_din,       32'h04030201);

    // Reset in the middle of a word
    send(8'hE1, 0); send(8'hE2, 0);
    reset = 1'b1; tick(); reset = 1'b0;
    c0 = we_cnt;
    repeat (3) tick();
    chk("midrst_no_we", 32'(we_cnt), 32'(c0));
    pulse_start();
    send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0); send(8'hDD, 0);
    chk("post_rst_we",   32'(le_we),   32'd1);
    chk("post_rst_addr", 32'(le_addr), 32'd0);
    chk("post_rst_din",  le_din,       32'hDDCCBBAA);

    // Checksum image: 0xFFFFFFFF + 0x00000002
    reset = 1'b1; tick(); reset = 1'b0; tick();
    pulse_start();
    for (int i = 0; i < 4; i++) send(8'hFF, 0);
    send(8'h02, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    tick(); tick();
    chk("ck_done", 32'(ck_done), 32'd1);
`ifdef MEM_LOADER_CHECKSUM_EN
    chk("ck_sum", ck_sum, 32'h00000001);
`endif
    for (int i = 0; i < 8; i++) send(8'(i + 8'h30), 0);
    wait_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mem_loader
`default_nettype wire
